// File: rtl/and_hpc1_masked_pipe.sv
// and_hpc1_masked_pipe: HPC1 masked AND gadget, SHARES shares, stallable,
// valid-tracked, optional output register. Rising-edge clock_0, async reset_0 (low).
// Ports:
//   clock_0, reset_0     clock / async active-low reset
//   io_en                pipeline enable (0 = every flop holds)
//   io_in_valid          input operation valid
//   io_i0, io_i1         shares of operands a, b (bit i = share i)
//   p_rand               [NP-1:0] refresh, [2NP-1:NP] multiply randomness
//   io_o0                shares of c = a & b
//   io_out_valid         io_o0 holds a valid result
module and_hpc1_masked_pipe #(
  parameter int SHARES  = 5,
  parameter int OUT_REG = 0
) (
  input  logic                         clock_0,
  input  logic                         reset_0,
  input  logic                         io_en,
  input  logic                         io_in_valid,
  input  logic [SHARES-1:0]            io_i0,
  input  logic [SHARES-1:0]            io_i1,
  input  logic [SHARES*(SHARES-1)-1:0] p_rand,
  output logic [SHARES-1:0]            io_o0,
  output logic                         io_out_valid
);

  localparam int NP     = SHARES * (SHARES - 1) / 2;
  localparam int RAND_W = 2 * NP;
  localparam int VL     = 2 + ((OUT_REG != 0) ? 1 : 0);

  // lexicographic pair index of the unordered pair {i,j}
  function automatic int pidx(int i, int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * SHARES - lo * (lo + 1) / 2 + hi - lo - 1;
  endfunction

  logic [SHARES-1:0] v_d;
  logic [SHARES-1:0] a_q;
  logic [SHARES-1:0] v_q;
  logic [NP-1:0]     rm_q;

  logic [SHARES-1:0][SHARES-1:0] z_d;
  // each cross product stays its own flop so no glitch-combined
  // share pair ever reaches the compression tree
  (* keep = "true" *)
  logic [SHARES-1:0][SHARES-1:0] z_q;

  logic [SHARES-1:0] c;
  logic [VL-1:0]     vld_q;

  // refresh of b: each pair bit lands on both of its shares
  always_comb begin
    v_d = io_i1;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        if (j != i) begin
          v_d[i] = v_d[i] ^ p_rand[pidx(i, j)];
        end
      end
    end
  end

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      a_q  <= '0;
      v_q  <= '0;
      rm_q <= '0;
    end else if (io_en) begin
      a_q  <= io_i0;
      v_q  <= v_d;
      rm_q <= p_rand[RAND_W-1:NP];
    end
  end

  always_comb begin
    z_d = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        if (i == j) begin
          z_d[i][j] = a_q[i] & v_q[j];
        end else begin
          z_d[i][j] = (a_q[i] & v_q[j]) ^ rm_q[pidx(i, j)];
        end
      end
    end
  end

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      z_q <= '0;
    end else if (io_en) begin
      z_q <= z_d;
    end
  end

  always_comb begin
    c = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        c[i] = c[i] ^ z_q[i][j];
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [SHARES-1:0] o_q;
    always_ff @(posedge clock_0 or negedge reset_0) begin
      if (!reset_0) begin
        o_q <= '0;
      end else if (io_en) begin
        o_q <= c;
      end
    end
    assign io_o0 = o_q;
  end else begin : g_comb
    assign io_o0 = c;
  end

  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      vld_q <= '0;
    end else if (io_en) begin
      vld_q <= {vld_q[VL-2:0], io_in_valid};
    end
  end

  assign io_out_valid = vld_q[VL-1];

endmodule

// File: tb/tb_and_hpc1_masked_pipe.sv
// tb_and_hpc1_masked_pipe: table vectors, hand sequences and random ops
// against a closed-form share model for four gadget configurations.
module tb_and_hpc1_masked_pipe;

  typedef struct {
    logic [4:0] o;
    logic       c;
  } exp_t;

  typedef struct {
    logic [4:0]  a;
    logic [4:0]  b;
    logic [19:0] r;
    logic [4:0]  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic vin = 1'b0;
  logic fired = 1'b0;

  logic [4:0]  i0_5 = '0, i1_5 = '0;
  logic [19:0] r5 = '0;
  logic [2:0]  i0_3 = '0, i1_3 = '0;
  logic [5:0]  r3 = '0;
  logic [1:0]  i0_2 = '0, i1_2 = '0;
  logic [1:0]  r2 = '0;

  logic [4:0] o5, o5r;
  logic [2:0] o3;
  logic [1:0] o2;
  logic v5, v5r, v3, v2;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q5[$];
  exp_t q5r[$];
  exp_t q3[$];
  exp_t q2[$];

  vec_t tab[8];

  always #5 clk = ~clk;

  and_hpc1_masked_pipe #(.SHARES(5), .OUT_REG(0)) u5 (
    .clock_0(clk), .reset_0(rst_n), .io_en(en), .io_in_valid(vin),
    .io_i0(i0_5), .io_i1(i1_5), .p_rand(r5),
    .io_o0(o5), .io_out_valid(v5));

  and_hpc1_masked_pipe #(.SHARES(5), .OUT_REG(1)) u5r (
    .clock_0(clk), .reset_0(rst_n), .io_en(en), .io_in_valid(vin),
    .io_i0(i0_5), .io_i1(i1_5), .p_rand(r5),
    .io_o0(o5r), .io_out_valid(v5r));

  and_hpc1_masked_pipe #(.SHARES(3), .OUT_REG(0)) u3 (
    .clock_0(clk), .reset_0(rst_n), .io_en(en), .io_in_valid(vin),
    .io_i0(i0_3), .io_i1(i1_3), .p_rand(r3),
    .io_o0(o3), .io_out_valid(v3));

  and_hpc1_masked_pipe #(.SHARES(2), .OUT_REG(1)) u2 (
    .clock_0(clk), .reset_0(rst_n), .io_en(en), .io_in_valid(vin),
    .io_i0(i0_2), .io_i1(i1_2), .p_rand(r2),
    .io_o0(o2), .io_out_valid(v2));

  // c_i = a_i & XOR(b)  ^  XOR of multiply bits of every pair touching i
  function automatic logic [4:0] model(int s, logic [4:0] a,
                                       logic [4:0] b, logic [19:0] r);
    logic [4:0] c;
    int np, lo, hi, k;
    np = s * (s - 1) / 2;
    c = '0;
    for (int i = 0; i < s; i++) begin
      c[i] = a[i] & (^b);
      for (int j = 0; j < s; j++) begin
        if (j != i) begin
          lo = (i < j) ? i : j;
          hi = (i < j) ? j : i;
          k = lo * s - lo * (lo + 1) / 2 + hi - lo - 1;
          c[i] = c[i] ^ r[np + k];
        end
      end
    end
    return c;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic spurious(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: valid output with no pending operation", name);
  endtask

  always @(posedge clk) fired <= en & rst_n;

  always @(negedge clk) begin : m5
    exp_t e;
    if (fired && v5) begin
      if (q5.size() == 0) spurious("u5");
      else begin
        e = q5.pop_front();
        check("u5 shares", 32'(o5), 32'(e.o));
        check("u5 parity", 32'(^o5), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin : m5r
    exp_t e;
    if (fired && v5r) begin
      if (q5r.size() == 0) spurious("u5r");
      else begin
        e = q5r.pop_front();
        check("u5r shares", 32'(o5r), 32'(e.o));
        check("u5r parity", 32'(^o5r), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin : m3
    exp_t e;
    if (fired && v3) begin
      if (q3.size() == 0) spurious("u3");
      else begin
        e = q3.pop_front();
        check("u3 shares", 32'(o3), 32'(e.o));
        check("u3 parity", 32'(^o3), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin : m2
    exp_t e;
    if (fired && v2) begin
      if (q2.size() == 0) spurious("u2");
      else begin
        e = q2.pop_front();
        check("u2 shares", 32'(o2), 32'(e.o));
        check("u2 parity", 32'(^o2), 32'(e.c));
      end
    end
  end

  task automatic push(logic [4:0] e5);
    exp_t x;
    x.o = e5;
    x.c = (^i0_5) & (^i1_5);
    q5.push_back(x);
    q5r.push_back(x);
    x.o = model(3, 5'(i0_3), 5'(i1_3), 20'(r3));
    x.c = (^i0_3) & (^i1_3);
    q3.push_back(x);
    x.o = model(2, 5'(i0_2), 5'(i1_2), 20'(r2));
    x.c = (^i0_2) & (^i1_2);
    q2.push_back(x);
  endtask

  task automatic rnd_data();
    i0_5 = 5'($urandom); i1_5 = 5'($urandom); r5 = 20'($urandom);
    i0_3 = 3'($urandom); i1_3 = 3'($urandom); r3 = 6'($urandom);
    i0_2 = 2'($urandom); i1_2 = 2'($urandom); r2 = 2'($urandom);
  endtask

  task automatic op(logic [4:0] a5, logic [4:0] b5, logic [19:0] rr5,
                    logic [4:0] e5, logic [2:0] a3, logic [2:0] b3,
                    logic [5:0] rr3, logic [1:0] a2, logic [1:0] b2,
                    logic [1:0] rr2);
    i0_5 = a5; i1_5 = b5; r5 = rr5;
    i0_3 = a3; i1_3 = b3; r3 = rr3;
    i0_2 = a2; i1_2 = b2; r2 = rr2;
    en = 1'b1;
    vin = 1'b1;
    push(e5);
    @(posedge clk);
    #1;
  endtask

  task automatic op_rnd(output logic [4:0] e5);
    rnd_data();
    e5 = model(5, i0_5, i1_5, r5);
    op(i0_5, i1_5, r5, e5, i0_3, i1_3, r3, i0_2, i1_2, r2);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      en = 1'b1;
      vin = 1'b0;
      rnd_data();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic outs_zero(string tag);
    check({tag, " o5"}, 32'(o5), 0);
    check({tag, " o5r"}, 32'(o5r), 0);
    check({tag, " o3"}, 32'(o3), 0);
    check({tag, " o2"}, 32'(o2), 0);
    check({tag, " valids"}, 32'({v5, v5r, v3, v2}), 0);
  endtask

  task automatic queues_empty(string tag);
    check({tag, " q5"}, q5.size(), 0);
    check({tag, " q5r"}, q5r.size(), 0);
    check({tag, " q3"}, q3.size(), 0);
    check({tag, " q2"}, q2.size(), 0);
  endtask

  initial begin
    logic [4:0] ea;
    tab[0] = '{5'b10110, 5'b00001, 20'h00000, 5'b10110};
    tab[1] = '{5'b11111, 5'b00011, 20'h00000, 5'b00000};
    tab[2] = '{5'b01011, 5'b11100, 20'h00000, 5'b01011};
    tab[3] = '{5'b00000, 5'b00000, 20'h00400, 5'b00011};
    tab[4] = '{5'b11111, 5'b00000, 20'h003FF, 5'b00000};
    tab[5] = '{5'b10000, 5'b10000, 20'h80000, 5'b01000};
    tab[6] = '{5'b00001, 5'b00010, 20'h04000, 5'b00111};
    tab[7] = '{5'b11111, 5'b00001, 20'h007FF, 5'b11100};

    // reset state, clock running with enable high
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs_zero("reset");
    #2 rst_n = 1'b1;
    idle(2);

    // T1 on u5/u5r plus T2 on u3, single op then bubbles
    op(tab[0].a, tab[0].b, tab[0].r, tab[0].e,
       3'b000, 3'b000, 6'b001000, 2'b01, 2'b11, 2'b00);
    vin = 1'b0;
    check("t1 edge1 v5", 32'(v5), 0);
    check("t1 edge1 v5r", 32'(v5r), 0);
    @(posedge clk); #1;
    check("t1 edge2 v5", 32'(v5), 1);
    check("t1 edge2 o5", 32'(o5), 32'(5'b10110));
    check("t1 edge2 v5r", 32'(v5r), 0);
    check("t2 edge2 v3", 32'(v3), 1);
    check("t2 edge2 o3", 32'(o3), 32'(3'b011));
    @(posedge clk); #1;
    check("t1 edge3 v5", 32'(v5), 0);
    check("t1 edge3 v5r", 32'(v5r), 1);
    check("t1 edge3 o5r", 32'(o5r), 32'(5'b10110));
    @(posedge clk); #1;
    check("t1 edge4 v5r", 32'(v5r), 0);
    idle(2);

    // table vectors, back to back
    for (int t = 0; t < 8; t++) begin
      rnd_data();
      op(tab[t].a, tab[t].b, tab[t].r, tab[t].e,
         i0_3, i1_3, r3, i0_2, i1_2, r2);
    end
    idle(4);

    // T4: stall before the result, then stall while it is shown
    op_rnd(ea);
    en = 1'b0;
    vin = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check("t4 stall v5", 32'(v5), 0);
      check("t4 stall v5r", 32'(v5r), 0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    check("t4 edge2 v5", 32'(v5), 1);
    check("t4 edge2 o5", 32'(o5), 32'(ea));
    check("t4 edge2 v5r", 32'(v5r), 0);
    en = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      check("t4 hold v5", 32'(v5), 1);
      check("t4 hold o5", 32'(o5), 32'(ea));
    end
    en = 1'b1;
    @(posedge clk); #1;
    check("t4 edge3 v5", 32'(v5), 0);
    check("t4 edge3 v5r", 32'(v5r), 1);
    check("t4 edge3 o5r", 32'(o5r), 32'(ea));
    idle(4);

    // T6: SHARES=2 exhaustive share splits and randomness
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int r = 0; r < 4; r++) begin
          rnd_data();
          op(i0_5, i1_5, r5, model(5, i0_5, i1_5, r5),
             i0_3, i1_3, r3, 2'(a), 2'(b), 2'(r));
        end
      end
    end

    // T3: random ops with occasional bubbles and stalls
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(7) != 0);
      vin = ($urandom_range(5) != 0);
      rnd_data();
      if (en && vin) push(model(5, i0_5, i1_5, r5));
      @(posedge clk); #1;
    end
    idle(5);
    queues_empty("drain1");

    // T5: reset between edges 1 and 2 of an op
    op_rnd(ea);
    vin = 1'b0;
    #2 rst_n = 1'b0;
    q5.delete(); q5r.delete(); q3.delete(); q2.delete();
    #1;
    outs_zero("t5 async");
    @(posedge clk); #1;
    outs_zero("t5 held");
    #2 rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      idle(1);
      check("t5 no stale", 32'({v5, v5r, v3, v2}), 0);
    end
    for (int n = 0; n < 20; n++) op_rnd(ea);
    idle(5);
    queues_empty("drain2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
